// File: rtl/load_store_unit_pkg.sv
// Shared CPU definitions for the load/store path: FSM states, instruction bit
// positions for single data transfers, and the effective-address helper.
package load_store_unit_pkg;

  localparam int unsigned LSU_DATA_W = 32;

  // Single-data-transfer bit positions, shared with the instruction decoder.
  localparam int unsigned INSN_L_BIT = 20;
  localparam int unsigned INSN_W_BIT = 21;
  localparam int unsigned INSN_B_BIT = 22;
  localparam int unsigned INSN_U_BIT = 23;
  localparam int unsigned INSN_P_BIT = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_LOAD_WB = 2'd2,
    ST_BASE_WB = 2'd3
  } lsu_state_e;

  // Immediate offset applied to the base, wrapping modulo 2^32.
  function automatic logic [LSU_DATA_W-1:0] lsu_eff_addr(
    input logic [LSU_DATA_W-1:0] base,
    input logic [11:0]           off,
    input logic                  up
  );
    logic [LSU_DATA_W-1:0] off_ext;
    off_ext = {{(LSU_DATA_W-12){1'b0}}, off};
    return up ? (base + off_ext) : (base - off_ext);
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Byte-lane steering for the load/store unit: byte enables, store-data
// replication and load-data rotate/extract, all selected by addr[1:0].
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [1:0]            lane_i,
  input  logic                  byte_i,
  input  logic [LSU_DATA_W-1:0] store_data_i,
  input  logic [LSU_DATA_W-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [LSU_DATA_W-1:0] wdata_o,
  output logic [LSU_DATA_W-1:0] load_data_o
);

  logic [2*LSU_DATA_W-1:0] rdata_dbl;
  logic [2*LSU_DATA_W-1:0] rdata_rot;
  logic [7:0]              lane_byte;

  assign rdata_dbl = {rdata_i, rdata_i};
  assign rdata_rot = rdata_dbl >> {lane_i, 3'b000};

  always_comb begin
    lane_byte = '0;
    case (lane_i)
      2'd0: lane_byte = rdata_i[7:0];
      2'd1: lane_byte = rdata_i[15:8];
      2'd2: lane_byte = rdata_i[23:16];
      2'd3: lane_byte = rdata_i[31:24];
      default: lane_byte = '0;
    endcase
  end

  always_comb begin
    be_o        = '1;
    wdata_o     = store_data_i;
    load_data_o = rdata_rot[LSU_DATA_W-1:0];
    if (byte_i) begin
      be_o        = 4'b0001 << lane_i;
      wdata_o     = {4{store_data_i[7:0]}};
      load_data_o = {{(LSU_DATA_W-8){1'b0}}, lane_byte};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle LDR/STR unit: captures the request, runs one bus transaction,
// then issues Rd write-back followed by optional Rn write-back.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              is_load_in,
  input  logic              byte_in,
  input  logic              up_in,
  input  logic              pre_in,
  input  logic              wback_in,
  input  logic [11:0]       offset_in,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] store_data_in,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [3:0]        mem_be_out,
  output logic [ADDR_W-1:0] mem_wdata_out,
  input  logic              mem_ack_in,
  input  logic [ADDR_W-1:0] mem_rdata_in,
  output logic [ADDR_W-1:0] rd_wdata_out,
  output logic              rd_we_out,
  output logic [ADDR_W-1:0] base_wdata_out,
  output logic              base_we_out,
  output logic              busy_out,
  output logic              done_out
);

  lsu_state_e        state_q, state_d;
  logic              is_load_q, byte_q, wb_q;
  logic [ADDR_W-1:0] addr_q, eff_q, sdata_q, rd_q;
  logic              done_q;

  logic [ADDR_W-1:0] eff_d, addr_d;
  logic              accept;
  logic              acked;
  logic [3:0]        lane_be;
  logic [ADDR_W-1:0] lane_wdata, lane_rdata;

  assign accept = (state_q == ST_IDLE) && start_in;
  assign acked  = (state_q == ST_REQ) && mem_ack_in;
  assign eff_d  = lsu_eff_addr(base_in, offset_in, up_in);
  assign addr_d = pre_in ? eff_d : base_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      is_load_q <= 1'b0;
      byte_q    <= 1'b0;
      wb_q      <= 1'b0;
      addr_q    <= '0;
      eff_q     <= '0;
      sdata_q   <= '0;
    end else if (accept) begin
      is_load_q <= is_load_in;
      byte_q    <= byte_in;
      wb_q      <= wback_in || !pre_in;
      addr_q    <= addr_d;
      eff_q     <= eff_d;
      sdata_q   <= store_data_in;
    end
  end

  lsu_byte_lane u_lane (
    .lane_i       (addr_q[1:0]),
    .byte_i       (byte_q),
    .store_data_i (sdata_q),
    .rdata_i      (mem_rdata_in),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_in) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ack_in) begin
          if (is_load_q)  state_d = ST_LOAD_WB;
          else if (wb_q)  state_d = ST_BASE_WB;
          else            state_d = ST_IDLE;
        end
      end
      ST_LOAD_WB: state_d = wb_q ? ST_BASE_WB : ST_IDLE;
      ST_BASE_WB: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
      if (acked && is_load_q) rd_q <= lane_rdata;
    end
  end

  // Bus outputs are decoded from state so reset drops the request without a clock.
  assign mem_req_out    = (state_q == ST_REQ);
  assign mem_we_out     = mem_req_out && !is_load_q;
  assign mem_addr_out   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_be_out     = mem_req_out ? lane_be : 4'b0000;
  assign mem_wdata_out  = (mem_req_out && !is_load_q) ? lane_wdata : '0;
  assign rd_wdata_out   = rd_q;
  assign rd_we_out      = (state_q == ST_LOAD_WB);
  assign base_wdata_out = eff_q;
  assign base_we_out    = (state_q == ST_BASE_WB);
  assign busy_out       = (state_q != ST_IDLE);
  assign done_out       = done_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transfers against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_load, byte_b, up, pre, wback;
  logic [11:0] offset;
  logic [31:0] base, sdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] rd_wdata, base_wdata;
  logic        rd_we, base_we, busy, done;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [31:0] model_rd   = '0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .is_load_in(is_load),
    .byte_in(byte_b), .up_in(up), .pre_in(pre), .wback_in(wback),
    .offset_in(offset), .base_in(base), .store_data_in(sdata),
    .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_be_out(mem_be), .mem_wdata_out(mem_wdata), .mem_ack_in(mem_ack),
    .mem_rdata_in(mem_rdata), .rd_wdata_out(rd_wdata), .rd_we_out(rd_we),
    .base_wdata_out(base_wdata), .base_we_out(base_we), .busy_out(busy),
    .done_out(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int unsigned i);
    return w[8*i +: 8];
  endfunction

  task automatic scramble_inputs();
    is_load = 1'($urandom); byte_b = 1'($urandom); up = 1'($urandom);
    pre = 1'($urandom); wback = 1'($urandom); offset = 12'($urandom);
    base = $urandom; sdata = $urandom;
  endtask

  // One full transfer; k = cycle of ack (1 = zero wait states).
  task automatic run_txn(input logic ld, input logic bt, input logic u, input logic p,
                         input logic w, input logic [11:0] off, input logic [31:0] b,
                         input logic [31:0] d, input logic [31:0] rdv,
                         input int unsigned k, input logic spurious);
    logic [31:0] eff, addr, exp_wdata, exp_res;
    logic [3:0]  exp_be;
    logic        do_wb;
    int unsigned lane;
    eff   = u ? b + 32'(off) : b - 32'(off);
    addr  = p ? eff : b;
    lane  = int'(addr % 4);
    do_wb = w || !p;
    exp_be    = bt ? 4'(1 << lane) : 4'hF;
    exp_wdata = ld ? 32'h0 : (bt ? {4{d[7:0]}} : d);
    exp_res   = '0;
    for (int unsigned i = 0; i < 4; i++)
      exp_res[8*i +: 8] = bt ? ((i == 0) ? byte_of(rdv, lane) : 8'h00)
                             : byte_of(rdv, (i + lane) % 4);

    is_load = ld; byte_b = bt; up = u; pre = p; wback = w;
    offset = off; base = b; sdata = d; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    for (int unsigned c = 1; c <= k; c++) begin
      check("req", 32'(mem_req), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("we", 32'(mem_we), 32'(!ld));
      check("addr", mem_addr, {addr[31:2], 2'b00});
      check("be", 32'(mem_be), 32'(exp_be));
      check("wdata", mem_wdata, exp_wdata);
      if (spurious && c == 1) start = 1'b1;
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? rdv : $urandom;
      @(posedge clk); @(negedge clk);
      start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
    end
    if (ld) begin
      model_rd = exp_res;
      check("rd_we", 32'(rd_we), 32'd1);
      check("rd_wdata", rd_wdata, model_rd);
      check("base_we_in_ldwb", 32'(base_we), 32'd0);
      check("done_early", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    if (do_wb) begin
      check("base_we", 32'(base_we), 32'd1);
      check("base_wdata", base_wdata, eff);
      check("rd_we_in_bwb", 32'(rd_we), 32'd0);
      check("done_early", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("req_end", 32'(mem_req), 32'd0);
    check("strobes_end", {30'd0, rd_we, base_we}, 32'd0);
    check("rd_hold", rd_wdata, model_rd);
    @(posedge clk); @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    is_load = 1'b0; byte_b = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    offset = '0; base = '0; sdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobes", {30'd0, rd_we, base_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdwdata", rd_wdata, 32'd0);
    check("rst_basewdata", base_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: (ld, byte, up, pre, w, off, base, data, rdata, k, spurious)
    run_txn(1, 0, 1, 1, 0, 12'h004, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1, 0);
    run_txn(0, 1, 0, 0, 0, 12'h010, 32'h0000_2003, 32'h1234_56A5, 32'h0, 1, 0);
    run_txn(1, 0, 1, 1, 0, 12'h000, 32'h0000_3002, 32'h0, 32'h1122_3344, 1, 0);
    run_txn(1, 1, 1, 1, 0, 12'h000, 32'h0000_3002, 32'h0, 32'h1122_3344, 1, 0);
    run_txn(0, 0, 1, 1, 1, 12'h008, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0, 5, 0);
    run_txn(1, 0, 1, 0, 0, 12'hFFF, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 3, 1);
    run_txn(0, 0, 1, 1, 0, 12'h001, 32'h0000_0100, 32'h5555_AAAA, 32'h0, 1, 1);

    // Ack outside REQ must not start anything.
    mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_done", 32'(done), 32'd0);

    // Reset in the middle of a waiting request.
    is_load = 1'b1; pre = 1'b0; wback = 1'b1; up = 1'b1; offset = 12'h040;
    base = 32'h0000_8000; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_req), 32'd0);
    check("async_busy_drop", 32'(busy), 32'd0);
    mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    check("rst_no_strobes", {30'd0, rd_we, base_we}, 32'd0);
    check("rst_no_done", 32'(done), 32'd0);
    model_rd = '0;
    check("rst_rd_cleared", rd_wdata, model_rd);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1, 0, 0, 1, 1, 12'h00C, 32'h0000_4000, 32'h0, 32'h8765_4321, 2, 0);

    // Randomized transfers.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] rb;
      rb = $urandom;
      if (t % 4 == 3) rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              12'($urandom), rb, $urandom, $urandom,
              $urandom_range(1, 4), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
